// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file.
// Two asynchronous read ports and one synchronous write port. x0 is a constant
// zero with no storage behind it. x2 (sp) and x3 (gp) come out of reset holding
// their ABI start values. There is deliberately no write-through path, so a
// same-cycle read of rd returns the old value. That keeps the single-cycle
// datapath loop (read -> ALU -> write-back) free of combinational cycles.
module register_file #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Flat view of every architectural register. Entry 0 is tied to zero, so
  // the read muxes need no special case for x0.
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  assign reg_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : gen_reg
      // Reset contents: the ABI pointers for sp and gp, zero for everything else.
      localparam logic [DATA_WIDTH-1:0] RESET_VAL =
        (gi == 2) ? SP_RESET :
        (gi == 3) ? GP_RESET : '0;

      logic [DATA_WIDTH-1:0] reg_q;
      logic [DATA_WIDTH-1:0] reg_d;
      logic                  wr_hit;

      assign wr_hit = Reg_Write_i && (Write_Register_i == ADDR_WIDTH'(gi));

      // Next-state: load the write-back data only when this register is addressed.
      always_comb begin
        reg_d = reg_q;
        if (wr_hit) begin
          reg_d = Write_Data_i;
        end
      end

      // Storage flop. Reset wins over a write on the same edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          reg_q <= RESET_VAL;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign reg_view[gi] = reg_q;
    end
  endgenerate

  // Zero-latency read muxes. They return the pre-edge contents, with no forwarding.
  always_comb begin
    Read_Data_1_o = reg_view[Read_Register_1_i];
    Read_Data_2_o = reg_view[Read_Register_2_i];
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file.
// The stimulus process drives one vector per cycle and queues the expected
// read-port values. The monitor pops the queue and compares on the falling edge.
module tb_register_file;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_VAL = 32'h1000_8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Reg_Write_i = 1'b0;
  logic [4:0]  Write_Register_i = '0;
  logic [31:0] Write_Data_i = '0;
  logic [4:0]  Read_Register_1_i = '0;
  logic [4:0]  Read_Register_2_i = '0;
  logic [31:0] Read_Data_1_o;
  logic [31:0] Read_Data_2_o;

  logic        sample_valid = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  exp_t exp_q [$];

  register_file dut (
    .clk              (clk),
    .reset            (reset),
    .Reg_Write_i      (Reg_Write_i),
    .Write_Register_i (Write_Register_i),
    .Write_Data_i     (Write_Data_i),
    .Read_Register_1_i(Read_Register_1_i),
    .Read_Register_2_i(Read_Register_2_i),
    .Read_Data_1_o    (Read_Data_1_o),
    .Read_Data_2_o    (Read_Data_2_o)
  );

  always #5 clk = ~clk;

  // Expected contents of a freshly reset register file.
  function automatic logic [31:0] reset_val(input int idx);
    if (idx == 2) return SP_VAL;
    if (idx == 3) return GP_VAL;
    return 32'h0;
  endfunction

  // Drive one cycle of inputs just after the rising edge. When chk is set,
  // the expected read values for this cycle are queued. The write takes
  // effect at the next rising edge, so the expectations are pre-write.
  task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic chk,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    Reg_Write_i       = we;
    Write_Register_i  = rd;
    Write_Data_i      = wd;
    Read_Register_1_i = rs1;
    Read_Register_2_i = rs2;
    sample_valid      = chk;
    if (chk) begin
      e.e1 = e1;
      e.e2 = e2;
      e.name = name;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare both read ports against the oldest queued expectation.
  always @(negedge clk) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: sample with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors += 2;
        if (Read_Data_1_o !== e.e1) begin
          miscompares++;
          $display("FAIL %s rd1: got %h expected %h", e.name, Read_Data_1_o, e.e1);
        end
        if (Read_Data_2_o !== e.e2) begin
          miscompares++;
          $display("FAIL %s rd2: got %h expected %h", e.name, Read_Data_2_o, e.e2);
        end
        $display("vec %-16s rs1=%0d rd1=%h rs2=%0d rd2=%h", e.name,
                 Read_Register_1_i, Read_Data_1_o, Read_Register_2_i, Read_Data_2_o);
      end
    end
  end

  initial begin
    // Reset is high before the first edge. Contents count as valid from that edge on.
    drive(1, 0, 0, 0, 2, 3, 1, SP_VAL, GP_VAL, "reset_held");
    drive(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, "reset_held_0_1");

    // Sweep every register after reset, using the two ports in opposite directions.
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, reset_val(i), reset_val(31 - i),
            "reset_sweep");
    end

    // Basic write, then read the same index on both ports.
    drive(0, 1, 5, 32'hDEADBEEF, 5, 5, 1, 32'h0, 32'h0, "wr_x5_pre");
    drive(0, 0, 0, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, "rd_x5");

    // A write to x0 is dropped.
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 5, 1, 32'h0, 32'hDEADBEEF, "wr_x0");
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "rd_x0");

    // Same-cycle hazard: the old value until the edge, the new value after it.
    drive(0, 1, 7, 32'h00000011, 7, 0, 1, 32'h0, 32'h0, "wr_x7_11");
    drive(0, 1, 7, 32'h00000022, 7, 7, 1, 32'h11, 32'h11, "hazard_pre");
    drive(0, 0, 0, 0, 7, 0, 1, 32'h22, 32'h0, "hazard_post");

    // With the write enable low, the write inputs are ignored.
    drive(0, 0, 9, 32'h12345678, 9, 0, 1, 32'h0, 32'h0, "we0_x9");
    drive(0, 0, 0, 0, 9, 5, 1, 32'h0, 32'hDEADBEEF, "we0_x9_post");

    // Full-width data pattern in the top register.
    drive(0, 1, 31, 32'h80000001, 31, 1, 1, 32'h0, 32'h0, "wr_x31");
    drive(0, 1, 2, 32'hCAFE0000, 31, 31, 1, 32'h80000001, 32'h80000001, "rd_x31_wr_x2");

    // Reset and a write on the same edge: reset wins, and sp goes back to its ABI value.
    drive(1, 1, 4, 32'hA5A5A5A5, 2, 4, 1, 32'hCAFE0000, 32'h0, "rst_vs_wr_pre");
    drive(0, 0, 0, 0, 4, 2, 1, 32'h0, SP_VAL, "rst_vs_wr_post");
    drive(0, 0, 0, 0, 5, 31, 1, 32'h0, 32'h0, "rst_cleared");
    drive(0, 0, 0, 0, 7, 3, 1, 32'h0, GP_VAL, "rst_cleared_gp");

    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    Reg_Write_i  = 1'b0;

    // Bounded drain: every queued expectation must have been consumed.
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit RISC-V integer register file for the single-cycle core.
- Sits directly upstream of the ALU:
  - Read port 1 drives the ALU A operand.
  - Read port 2 drives the ALU B operand, or the B-source mux when an immediate is selected.
- Write port is fed by the write-back mux (ALU result / memory data / PC+4).
- Register x0 is hardwired to zero. x2 (sp) and x3 (gp) reset to non-zero ABI values.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, width of register index ports (2^ADDR_WIDTH registers).
- SP_RESET, 32'h7FFF_EFFC, reset value of x2 (stack pointer).
- GP_RESET, 32'h1000_8000, reset value of x3 (global pointer).

Ports:
- clk  input  1  Core clock; all state updates on rising edge.
- reset  input  1  Synchronous, active-high reset, sampled on rising edge of clk.
- Reg_Write_i  input  1  Write enable from control unit.
- Write_Register_i  input  ADDR_WIDTH  Destination index (rd).
- Write_Data_i  input  DATA_WIDTH  Write-back data.
- Read_Register_1_i  input  ADDR_WIDTH  Source index rs1.
- Read_Register_2_i  input  ADDR_WIDTH  Source index rs2.
- Read_Data_1_o  output  DATA_WIDTH  Contents of rs1, to ALU A_i.
- Read_Data_2_o  output  DATA_WIDTH  Contents of rs2, to B-source mux / ALU B_i.

Behaviour:
- Storage:
  - 2^ADDR_WIDTH registers of DATA_WIDTH bits each, held in flops (no inferred RAM).
  - x0 has no storage element.
- Reset (reset=1 at rising edge):
  - x2 <= SP_RESET, x3 <= GP_RESET, all other registers <= 0.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-program clears state at that edge only; no extra recovery cycles.
- Write:
  - At a rising edge with reset=0, Reg_Write_i=1 and Write_Register_i != 0: register[Write_Register_i] <= Write_Data_i.
  - Writes to index 0 are silently dropped.
  - Reg_Write_i=0 leaves all registers unchanged regardless of the other write inputs.
- Read:
  - Purely combinational, asynchronous, zero latency.
  - Read_Data_n_o = 0 when the index is 0, else register[index].
  - Both ports may read the same index simultaneously.
- No write-through forwarding:
  - A read of the register being written in the same cycle returns the pre-edge value.
  - The new value appears only after the rising edge.
  - Forwarding is forbidden: in the single-cycle datapath rd==rs1 would close a combinational loop (read -> ALU -> write-back -> read).
- Output values while reset is held:
  - Outputs reflect the reset contents from the first reset edge onward.
  - Before that first edge, contents are undefined; the bench must apply reset before checking.
- Width rules:
  - Data passes unmodified; no sign handling inside the block (the ALU treats operands as signed).
  - Index ports are exactly ADDR_WIDTH bits; no out-of-range index exists.
- Timing: one write per cycle, two reads per cycle, no stalls, no handshake.

Test Plan:
- Reset: hold reset 2 cycles, then sweep rs1 over 0..31. Required: x2=32'h7FFFEFFC, x3=32'h10008000, all others 0.
- Write/read: write x5=32'hDEADBEEF (Reg_Write_i=1); next cycle rs1=5, rs2=5. Both outputs = 32'hDEADBEEF.
- x0 protection: write x0=32'hFFFFFFFF. Read rs1=0 -> 0.
- Same-cycle hazard:
  - With x7=32'h00000011, write x7=32'h00000022 while rs1=7.
  - Before the edge: Read_Data_1_o=32'h11. After the edge: 32'h22.
- Write enable gating: Reg_Write_i=0, rd=9, data=32'h12345678. x9 remains 0.
- Reset vs write: assert reset and a write of x4=32'hA5A5A5A5 on the same edge. x4 reads 0 afterwards, and x2 returns to SP_RESET.
